// File: rtl/knn_pkg.sv
// Shared types and default sizing for the k-nearest-neighbour sort controller.
package knn_pkg;

    localparam int unsigned DEF_L      = 4;
    localparam int unsigned DEF_W      = 16;
    localparam int unsigned DEF_TYPE_W = 3;
    localparam int unsigned DEF_K      = 4;

    // Distance used for empty best-list slots and unfilled batch lanes.
    localparam logic [DEF_W-1:0] PAD_DIST = '1;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SORT,
        UPDATE,
        DONE
    } state_t;

endpackage

// File: rtl/knn_batch_buf.sv
// Batch register file: lanes 0..K-1 hold the running best list, lanes K..N-1 the
// samples of the batch being filled. Supports clear, single-lane write and capture.
module knn_batch_buf
    import knn_pkg::*;
#(
    parameter int unsigned L      = DEF_L,
    parameter int unsigned W      = DEF_W,
    parameter int unsigned TYPE_W = DEF_TYPE_W,
    parameter int unsigned K      = DEF_K
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       capture,
    input  logic                       wr_en,
    input  logic [L-1:0]               wr_lane,
    input  logic [W-1:0]               wr_dist,
    input  logic [TYPE_W-1:0]          wr_type,
    input  logic [W*K-1:0]             cap_dist,
    input  logic [TYPE_W*K-1:0]        cap_type,
    output logic [W*(2**L)-1:0]        lane_dist,
    output logic [TYPE_W*(2**L)-1:0]   lane_type
);

    localparam int unsigned N = 2 ** L;

    logic [W-1:0]      dist_q [N];
    logic [TYPE_W-1:0] type_q [N];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                dist_q[i] <= '1;
                type_q[i] <= '0;
            end
        end else if (clear) begin
            for (int unsigned i = 0; i < N; i++) begin
                dist_q[i] <= '1;
                type_q[i] <= '0;
            end
        end else if (capture) begin
            // New best list comes from the sorter; the sample lanes are re-padded
            // so a short follow-on batch needs no separate pad step.
            for (int unsigned i = 0; i < K; i++) begin
                dist_q[i] <= cap_dist[W*i +: W];
                type_q[i] <= cap_type[TYPE_W*i +: TYPE_W];
            end
            for (int unsigned i = K; i < N; i++) begin
                dist_q[i] <= '1;
                type_q[i] <= '0;
            end
        end else if (wr_en) begin
            dist_q[wr_lane] <= wr_dist;
            type_q[wr_lane] <= wr_type;
        end
    end

    always_comb begin
        lane_dist = '0;
        lane_type = '0;
        for (int unsigned i = 0; i < N; i++) begin
            lane_dist[W*i +: W]           = dist_q[i];
            lane_type[TYPE_W*i +: TYPE_W] = type_q[i];
        end
    end

endmodule

// File: rtl/knn_sort_ctrl.sv
// Streams samples into batches for an external sorter and keeps the K nearest.
// Optional sorter watchdog and error port: define KNN_SORT_CTRL_WATCHDOG_EN.
module knn_sort_ctrl
    import knn_pkg::*;
#(
    parameter int unsigned L       = DEF_L,
    parameter int unsigned W       = DEF_W,
    parameter int unsigned TYPE_W  = DEF_TYPE_W,
    parameter int unsigned K       = DEF_K,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_dist,
    input  logic [TYPE_W-1:0]          in_type,
    input  logic                       in_last,
    output logic                       sort_in_valid,
    output logic                       sort_ascending,
    output logic [W*(2**L)-1:0]        sort_in,
    output logic [TYPE_W*(2**L)-1:0]   sort_in_type,
    input  logic [W*(2**L)-1:0]        sort_out,
    input  logic [TYPE_W*(2**L)-1:0]   sort_out_type,
    input  logic                       sort_out_valid,
    output logic [W*K-1:0]             knn_dist,
    output logic [TYPE_W*K-1:0]        knn_type,
    output logic                       knn_valid,
    output logic                       busy
`ifdef KNN_SORT_CTRL_WATCHDOG_EN
    ,
    output logic                       error
`endif
);

    localparam int unsigned N        = 2 ** L;
    localparam logic [L-1:0] LAST_CNT = L'(N - K - 1);
    localparam logic [L-1:0] K_LANE   = L'(K);

    state_t      state;
    logic [L-1:0] cnt;
    logic        last_seen;
    logic        accept;
    logic        buf_clear;
    logic        buf_capture;

    assign accept         = in_valid & in_ready;
    assign buf_clear      = (state == IDLE) && start;
    assign buf_capture    = (state == SORT) && sort_out_valid;
    assign sort_ascending = 1'b1;

    // Sorter lanes above K-1 are discarded by design.
    logic unused_sort_hi;
    assign unused_sort_hi = ^{sort_out[W*N-1:W*K], sort_out_type[TYPE_W*N-1:TYPE_W*K]};

    knn_batch_buf #(
        .L      (L),
        .W      (W),
        .TYPE_W (TYPE_W),
        .K      (K)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (buf_clear),
        .capture   (buf_capture),
        .wr_en     (accept),
        .wr_lane   (K_LANE + cnt),
        .wr_dist   (in_dist),
        .wr_type   (in_type),
        .cap_dist  (sort_out[W*K-1:0]),
        .cap_type  (sort_out_type[TYPE_W*K-1:0]),
        .lane_dist (sort_in),
        .lane_type (sort_in_type)
    );

`ifdef KNN_SORT_CTRL_WATCHDOG_EN
    localparam int unsigned      WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_cnt;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT == 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            last_seen     <= 1'b0;
            in_ready      <= 1'b0;
            sort_in_valid <= 1'b0;
            knn_valid     <= 1'b0;
            busy          <= 1'b0;
            knn_dist      <= '1;
            knn_type      <= '0;
`ifdef KNN_SORT_CTRL_WATCHDOG_EN
            wd_cnt        <= '0;
            error         <= 1'b0;
`endif
        end else begin
            sort_in_valid <= 1'b0;
            knn_valid     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FILL;
                        cnt       <= '0;
                        last_seen <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (in_last || cnt == LAST_CNT) begin
                            state         <= SORT;
                            in_ready      <= 1'b0;
                            sort_in_valid <= 1'b1;
                            last_seen     <= in_last;
`ifdef KNN_SORT_CTRL_WATCHDOG_EN
                            wd_cnt        <= '0;
`endif
                        end else begin
                            cnt <= cnt + L'(1);
                        end
                    end
                end
                SORT: begin
                    if (sort_out_valid) begin
                        state <= UPDATE;
`ifdef KNN_SORT_CTRL_WATCHDOG_EN
                    end else if (wd_cnt == WD_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
`endif
                    end
                end
                UPDATE: begin
                    if (last_seen) begin
                        state     <= DONE;
                        knn_valid <= 1'b1;
                        knn_dist  <= sort_in[W*K-1:0];
                        knn_type  <= sort_in_type[TYPE_W*K-1:0];
                    end else begin
                        state    <= FILL;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_knn_sort_ctrl.sv
// Self-checking bench for knn_sort_ctrl with a behavioural sorter and a rank-based
// reference for batch contents and final K-nearest results.
module tb_knn_sort_ctrl;

    localparam int W  = 16;
    localparam int TW = 3;
    localparam int L  = 4;
    localparam int N  = 16;
    localparam int K  = 4;
    localparam int B  = N - K;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic [W-1:0]  in_dist = '0;
    logic [TW-1:0] in_type = '0;
    logic in_ready, sort_in_valid, sort_ascending, sort_out_valid, knn_valid, busy;
    logic [W*N-1:0]  sort_in, sort_out;
    logic [TW*N-1:0] sort_in_type, sort_out_type;
    logic [W*K-1:0]  knn_dist;
    logic [TW*K-1:0] knn_type;
`ifdef KNN_SORT_CTRL_WATCHDOG_EN
    logic error;
`endif

    logic            model_valid = 1'b0;
    logic [W*N-1:0]  model_out = '0;
    logic [TW*N-1:0] model_out_type = '0;
    logic            spur_valid = 1'b0;
    bit              sorter_en = 1'b1;
    int unsigned     sorter_lat = 5;

    int n_cmp = 0;
    int n_mis = 0;
    int n_launch = 0;
    int n_knn = 0;

    logic [W-1:0]  qd[$];
    logic [TW-1:0] qt[$];

    assign sort_out_valid = model_valid | spur_valid;
    assign sort_out       = spur_valid ? '0 : model_out;
    assign sort_out_type  = spur_valid ? '1 : model_out_type;

    knn_sort_ctrl #(
        .L       (L),
        .W       (W),
        .TYPE_W  (TW),
        .K       (K),
        .TIMEOUT (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_dist        (in_dist),
        .in_type        (in_type),
        .in_last        (in_last),
        .sort_in_valid  (sort_in_valid),
        .sort_ascending (sort_ascending),
        .sort_in        (sort_in),
        .sort_in_type   (sort_in_type),
        .sort_out       (sort_out),
        .sort_out_type  (sort_out_type),
        .sort_out_valid (sort_out_valid),
        .knn_dist       (knn_dist),
        .knn_type       (knn_type),
        .knn_valid      (knn_valid),
        .busy           (busy)
`ifdef KNN_SORT_CTRL_WATCHDOG_EN
        ,
        .error          (error)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural sorter: stable ascending sort, fixed latency after the launch pulse.
    initial begin
        logic [W-1:0]  d [N];
        logic [TW-1:0] t [N];
        logic [W-1:0]  kd;
        logic [TW-1:0] kt;
        int j;
        forever begin
            @(negedge clk);
            if (sort_in_valid && sorter_en) begin
                for (int i = 0; i < N; i++) begin
                    d[i] = sort_in[W*i +: W];
                    t[i] = sort_in_type[TW*i +: TW];
                end
                for (int i = 1; i < N; i++) begin
                    kd = d[i];
                    kt = t[i];
                    j = i - 1;
                    while (j >= 0 && d[j] > kd) begin
                        d[j+1] = d[j];
                        t[j+1] = t[j];
                        j--;
                    end
                    d[j+1] = kd;
                    t[j+1] = kt;
                end
                repeat (sorter_lat) @(negedge clk);
                for (int i = 0; i < N; i++) begin
                    model_out[W*i +: W]       = d[i];
                    model_out_type[TW*i +: TW] = t[i];
                end
                model_valid = 1'b1;
                @(negedge clk);
                model_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sort_in_valid) n_launch++;
            if (knn_valid) n_knn++;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // j-th smallest of the first 'upto' query samples (distinct distances), or pad.
    function automatic void exp_best(input int upto, input int j,
                                     output logic [W-1:0] d, output logic [TW-1:0] t);
        int rank;
        d = '1;
        t = '0;
        for (int i = 0; i < upto; i++) begin
            rank = 0;
            for (int k = 0; k < upto; k++)
                if (qd[k] < qd[i]) rank++;
            if (rank == j) begin
                d = qd[i];
                t = qt[i];
            end
        end
    endfunction

    function automatic bit in_query(input logic [W-1:0] d);
        foreach (qd[i]) if (qd[i] == d) return 1'b1;
        return 1'b0;
    endfunction

    task automatic gen_random(input int n);
        logic [W-1:0] d;
        qd.delete();
        qt.delete();
        for (int i = 0; i < n; i++) begin
            do d = W'($urandom_range(0, 16'hFFFE)); while (in_query(d));
            qd.push_back(d);
            qt.push_back(TW'($urandom_range(0, 7)));
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic [TW-1:0] t, input logic last);
        bit accepted;
        accepted = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        in_dist  = d;
        in_type  = t;
        in_last  = last;
        in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (in_ready) begin
                accepted = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("accept", {255'd0, accepted}, 256'd1);
    endtask

    task automatic run_query(input bit start_in_sort, input bit spur_fill);
        int n, base, nb, l0, cnt_b;
        bit got;
        logic [W*N-1:0]  ed;
        logic [TW*N-1:0] et;
        logic [W*K-1:0]  ek;
        logic [TW*K-1:0] etk;
        logic [W-1:0]    d;
        logic [TW-1:0]   t;
        n = qd.size();
        base = 0;
        nb = 0;
        l0 = n_launch;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("fill_entry", {busy, in_ready}, 2'b11);
        if (spur_fill) begin
            spur_valid = 1'b1;
            @(negedge clk);
            spur_valid = 1'b0;
        end
        while (base < n) begin
            cnt_b = (n - base < B) ? n - base : B;
            for (int m = 0; m < cnt_b; m++)
                send(qd[base+m], qt[base+m], (base + m == n - 1));
            check("launch_pulse", sort_in_valid, 1);
            for (int i = 0; i < N; i++) begin
                if (i < K) exp_best(base, i, d, t);
                else if (i - K < cnt_b) begin
                    d = qd[base+i-K];
                    t = qt[base+i-K];
                end else begin
                    d = '1;
                    t = '0;
                end
                ed[W*i +: W]   = d;
                et[TW*i +: TW] = t;
            end
            check("batch_dist", sort_in, ed);
            check("batch_type", sort_in_type, et);
            if (start_in_sort) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("sort_hold", {sort_in_valid, in_ready, busy}, 3'b001);
            check("sort_stable", sort_in, ed);
            base += cnt_b;
            nb++;
        end
        got = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (knn_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("knn_wait", {255'd0, got}, 256'd1);
        for (int j = 0; j < K; j++) begin
            exp_best(n, j, d, t);
            ek[W*j +: W]    = d;
            etk[TW*j +: TW] = t;
        end
        check("knn_dist", knn_dist, ek);
        check("knn_type", knn_type, etk);
        check("launch_count", n_launch - l0, nb);
        @(negedge clk);
        check("done_exit", {knn_valid, busy}, 2'b00);
        check("knn_hold", knn_dist, ek);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ctrl"}, {in_ready, sort_in_valid, knn_valid, busy, sort_ascending}, 5'b00001);
        check({tag, "_sort_in"}, sort_in, {W*N{1'b1}});
        check({tag, "_sort_in_type"}, sort_in_type, '0);
        check({tag, "_knn_dist"}, knn_dist, {W*K{1'b1}});
        check({tag, "_knn_type"}, knn_type, '0);
`ifdef KNN_SORT_CTRL_WATCHDOG_EN
        check({tag, "_error"}, error, 0);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single full batch: 120..10 step -10.
        qd.delete();
        qt.delete();
        for (int i = 0; i < 12; i++) begin
            qd.push_back(W'(120 - 10 * i));
            qt.push_back(TW'(i % 8));
        end
        sorter_lat = 5;
        run_query(1'b0, 1'b0);
        check("t1_knn", knn_dist, {16'd40, 16'd30, 16'd20, 16'd10});

        // Two batches: first minimum 50, second holds 5 and 7.
        qd.delete();
        qt.delete();
        for (int i = 0; i < 12; i++) qd.push_back(W'(160 - 10 * i));
        qd.push_back(16'd7);
        qd.push_back(16'd200);
        qd.push_back(16'd5);
        for (int i = 0; i < 9; i++) qd.push_back(W'(210 + 10 * i));
        for (int i = 0; i < 24; i++) qt.push_back(TW'($urandom_range(0, 7)));
        sorter_lat = 3;
        run_query(1'b0, 1'b0);
        check("t2_knn", knn_dist, {16'd60, 16'd50, 16'd7, 16'd5});

        // Short query padded out.
        qd.delete();
        qt.delete();
        qd.push_back(16'd9);
        qd.push_back(16'd3);
        qt.push_back(3'd5);
        qt.push_back(3'd6);
        run_query(1'b0, 1'b0);
        check("t3_knn", knn_dist, {16'hFFFF, 16'hFFFF, 16'd9, 16'd3});
        check("t3_type", knn_type, {3'd0, 3'd0, 3'd5, 3'd6});

        // start in SORT and spurious sorter result in FILL are ignored.
        gen_random(20);
        sorter_lat = 4;
        run_query(1'b1, 1'b1);

        for (int q = 0; q < 6; q++) begin
            gen_random($urandom_range(1, 40));
            sorter_lat = $urandom_range(1, 8);
            run_query(q[0], q[1]);
        end

        // Reset while waiting on the sorter, then a late result.
        qd.delete();
        qt.delete();
        qd.push_back(16'd100);
        qd.push_back(16'd200);
        qd.push_back(16'd300);
        for (int i = 0; i < 3; i++) qt.push_back(3'd1);
        sorter_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int m = 0; m < 3; m++) send(qd[m], qt[m], m == 2);
        check("rst_launch", sort_in_valid, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_values("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        spur_valid = 1'b1;
        @(negedge clk);
        spur_valid = 1'b0;
        @(negedge clk);
        check_reset_values("late_result");
        sorter_en = 1'b1;

        gen_random(15);
        sorter_lat = 2;
        run_query(1'b0, 1'b0);

`ifdef KNN_SORT_CTRL_WATCHDOG_EN
        begin
            int cyc, k0;
            bit got;
            qd.delete();
            qt.delete();
            qd.push_back(16'd42);
            qt.push_back(3'd2);
            sorter_en = 1'b0;
            k0 = n_knn;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            send(qd[0], qt[0], 1'b1);
            check("wd_launch", sort_in_valid, 1);
            cyc = 0;
            got = 1'b0;
            for (int c = 1; c <= 200; c++) begin
                @(negedge clk);
                if (error) begin
                    cyc = c;
                    got = 1'b1;
                    break;
                end
            end
            check("wd_seen", {255'd0, got}, 256'd1);
            check("wd_cycles", cyc, 64);
            check("wd_busy", busy, 0);
            repeat (10) @(negedge clk);
            check("wd_sticky", error, 1);
            check("wd_no_knn", n_knn - k0, 0);
            rst = 1'b0;
            @(negedge clk);
            check("wd_rst", error, 0);
            rst = 1'b1;
            sorter_en = 1'b1;
            @(negedge clk);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
